ac_controlador: RTL

//  Air-conditioner control FSM for the board top level. Compares the measured

---
 rtl/ac_controlador.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ac_controlador.sv
// ac_controlador: air-conditioner sequencing FSM.
// Compares the measured temperature against a setpoint, drives the compressor,
// fan and (optionally) heater, and enforces the minimum on-time, the compressor
// lockout and a fan post-run. The state code and a saturating start counter
// are exported for the debug displays.
// Optional heating mode: define AC_HEAT_EN. Without it AQUECE is unreachable
// and aquecedor stays 0.
//
// state    | code | meaning
// DESL     |  0   | system disabled, all drives off
// BLOQ     |  1   | compressor lockout (anti-short-cycle), drives off
// OCIOSO   |  2   | enabled and idle, watching temperature
// RESFRIA  |  3   | cooling: compressor and fan on
// POS_VENT |  4   | fan-only post-run after compressor/heater stops
// AQUECE   |  5   | heating: heater and fan on (AC_HEAT_EN only)

module ac_controlador #(
  parameter int TW       = 4,
  parameter int HYST     = 1,
  parameter int MIN_ON   = 3,
  parameter int MIN_OFF  = 4,
  parameter int FAN_POST = 2
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          liga,
  input  logic [TW-1:0] t_atual,
  input  logic [TW-1:0] t_alvo,
  output logic          compressor,
  output logic          ventilador,
  output logic          aquecedor,
  output logic [2:0]    estado,
  output logic [7:0]    partidas
);

  localparam int CNT_MAX = (MIN_ON > MIN_OFF)
                         ? ((MIN_ON  > FAN_POST) ? MIN_ON  : FAN_POST)
                         : ((MIN_OFF > FAN_POST) ? MIN_OFF : FAN_POST);
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    DESL     = 3'd0,
    BLOQ     = 3'd1,
    OCIOSO   = 3'd2,
    RESFRIA  = 3'd3,
    POS_VENT = 3'd4,
    AQUECE   = 3'd5
  } estado_t;

  estado_t       state, state_next;
  logic [CW-1:0] cnt;

  // One extra bit so that t_alvo + HYST cannot wrap around.
  logic [TW:0] t_atual_x, t_alvo_x, hyst_x;
  logic        muito_quente, frio_ok, min_on_ok, bloq_fim, pos_fim;

  assign t_atual_x    = {1'b0, t_atual};
  assign t_alvo_x     = {1'b0, t_alvo};
  assign hyst_x       = (TW+1)'(HYST);
  assign muito_quente = t_atual_x > (t_alvo_x + hyst_x);
  assign frio_ok      = t_atual_x <= t_alvo_x;
  assign min_on_ok    = cnt >= CW'(MIN_ON - 1);
  assign bloq_fim     = cnt == CW'(MIN_OFF - 1);
  assign pos_fim      = cnt == CW'(FAN_POST - 1);

`ifdef AC_HEAT_EN
  logic muito_frio, quente_ok;
  assign muito_frio = (t_atual_x + hyst_x) < t_alvo_x;
  assign quente_ok  = t_atual_x >= t_alvo_x;
`endif

  // State register; reset overrides every transition.
  always_ff @(posedge clk_2) begin
    if (reset) state <= DESL;
    else       state <= state_next;
  end

  // Dwell timer: restarts on every state change, saturates at the longest window.
  always_ff @(posedge clk_2) begin
    if (reset)                     cnt <= '0;
    else if (state_next != state)  cnt <= '0;
    else if (cnt != CW'(CNT_MAX))  cnt <= cnt + 1'b1;
  end

  // Compressor start counter, counts entries into RESFRIA and holds at 255.
  always_ff @(posedge clk_2) begin
    if (reset)
      partidas <= '0;
    else if (state_next == RESFRIA && state != RESFRIA && partidas != 8'hFF)
      partidas <= partidas + 8'd1;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      DESL:     if (liga) state_next = BLOQ;
      BLOQ: begin
        if (!liga)         state_next = DESL;
        else if (bloq_fim) state_next = OCIOSO;
      end
      OCIOSO: begin
        if (!liga)             state_next = DESL;
        else if (muito_quente) state_next = RESFRIA;
`ifdef AC_HEAT_EN
        else if (muito_frio)   state_next = AQUECE;
`endif
      end
      RESFRIA: begin
        if (!liga)                     state_next = POS_VENT;
        else if (min_on_ok && frio_ok) state_next = POS_VENT;
      end
      POS_VENT: if (pos_fim) state_next = liga ? BLOQ : DESL;
`ifdef AC_HEAT_EN
      AQUECE: begin
        if (!liga)                       state_next = POS_VENT;
        else if (min_on_ok && quente_ok) state_next = POS_VENT;
      end
`endif
      default:  state_next = DESL;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    compressor = 1'b0;
    ventilador = 1'b0;
    aquecedor  = 1'b0;
    case (state)
      RESFRIA: begin
        compressor = 1'b1;
        ventilador = 1'b1;
      end
      POS_VENT: ventilador = 1'b1;
`ifdef AC_HEAT_EN
      AQUECE: begin
        aquecedor  = 1'b1;
        ventilador = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign estado = state;

endmodule
